// File: rtl/dcache_sa_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dcache_sa_controller                                                       |
// | N-way set-associative write-back/write-allocate D-cache with LRU and       |
// | saturating hit/miss counters.                                              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module dcache_sa_controller #(
  parameter int WAYS      = 2,
  parameter int SETS      = 16,
  parameter int LINE_BITS = 256,
  parameter int CNT_W     = 16
) (
  input  logic                 Clk_i,
  input  logic                 Rst_i,
  input  logic                 MemRead_i,
  input  logic                 MemWrite_i,
  input  logic [31:0]          Addr_i,
  input  logic [31:0]          Data_i,
  output logic [31:0]          Data_o,
  output logic                 Stall_o,
  input  logic [LINE_BITS-1:0] MemData_i,
  input  logic                 MemAck_i,
  output logic [LINE_BITS-1:0] MemData_o,
  output logic [31:0]          MemAddr_o,
  output logic                 MemEnable_o,
  output logic                 MemWrite_o,
  output logic [CNT_W-1:0]     HitCount_o,
  output logic [CNT_W-1:0]     MissCount_o
);

  localparam int c_OFF_W  = $clog2(LINE_BITS / 8);
  localparam int c_WSEL_W = c_OFF_W - 2;
  localparam int c_IDX_W  = $clog2(SETS);
  localparam int c_TAG_W  = 32 - c_OFF_W - c_IDX_W;
  localparam int c_WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_ALLOCATE  = 2'd2,
    S_REFILL    = 2'd3
  } state_t;

  state_t r_state, w_next;

  logic                 r_valid [WAYS][SETS];
  logic                 r_dirty [WAYS][SETS];
  logic [c_WAY_W-1:0]   r_age   [WAYS][SETS];
  logic [c_TAG_W-1:0]   r_tag   [WAYS][SETS];
  logic [LINE_BITS-1:0] r_data  [WAYS][SETS];

  logic [LINE_BITS-1:0] r_line;
  logic [c_WAY_W-1:0]   r_victim;
  logic [c_IDX_W-1:0]   r_idx;
  logic [c_TAG_W-1:0]   r_mtag;
  logic                 r_fill_done;
  logic [CNT_W-1:0]     r_hit_cnt, r_miss_cnt;

  logic [c_IDX_W-1:0]   w_idx;
  logic [c_TAG_W-1:0]   w_tag;
  logic [c_WSEL_W-1:0]  w_wsel;
  logic                 w_req, w_hit, w_do_hit, w_do_miss;
  logic [c_WAY_W-1:0]   w_hit_way, w_victim;
  logic [1:0]           w_unused_addr;

  assign w_idx         = Addr_i[c_OFF_W +: c_IDX_W];
  assign w_tag         = Addr_i[31 -: c_TAG_W];
  assign w_wsel        = Addr_i[2 +: c_WSEL_W];
  assign w_unused_addr = Addr_i[1:0];
  assign w_req         = MemRead_i | MemWrite_i;
  assign HitCount_o    = r_hit_cnt;
  assign MissCount_o   = r_miss_cnt;

  // Victim: oldest way unless an invalid one exists, lowest index first.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    w_victim  = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_valid[w][w_idx] && (r_tag[w][w_idx] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = c_WAY_W'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_age[w][w_idx] == c_WAY_W'(WAYS - 1)) w_victim = c_WAY_W'(w);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!r_valid[w][w_idx]) w_victim = c_WAY_W'(w);
    end
  end

  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    Stall_o     = 1'b0;
    MemEnable_o = 1'b0;
    MemWrite_o  = 1'b0;
    MemAddr_o   = '0;
    MemData_o   = '0;
    Data_o      = '0;
    w_do_hit    = 1'b0;
    w_do_miss   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (w_hit) begin
            w_do_hit = 1'b1;
            if (!MemWrite_i) Data_o = r_data[w_hit_way][w_idx][w_wsel*32 +: 32];
          end else begin
            Stall_o   = 1'b1;
            w_do_miss = 1'b1;
            w_next    = (r_valid[w_victim][w_idx] && r_dirty[w_victim][w_idx]) ?
                        S_WRITEBACK : S_ALLOCATE;
          end
        end
      end
      S_WRITEBACK: begin
        Stall_o     = 1'b1;
        MemEnable_o = 1'b1;
        MemWrite_o  = 1'b1;
        MemAddr_o   = {r_tag[r_victim][r_idx], r_idx, {c_OFF_W{1'b0}}};
        MemData_o   = r_data[r_victim][r_idx];
        if (MemAck_i) w_next = S_ALLOCATE;
      end
      S_ALLOCATE: begin
        Stall_o     = 1'b1;
        MemEnable_o = 1'b1;
        MemAddr_o   = {r_mtag, r_idx, {c_OFF_W{1'b0}}};
        if (MemAck_i) w_next = S_REFILL;
      end
      S_REFILL: begin
        Stall_o = 1'b1;
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // A pending miss must not hold the pipeline while reset is asserted.
    if (Rst_i) Stall_o = 1'b0;
  end

  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) begin
      for (int w = 0; w < WAYS; w++) begin
        for (int s = 0; s < SETS; s++) begin
          r_valid[w][s] <= 1'b0;
          r_dirty[w][s] <= 1'b0;
          r_age[w][s]   <= c_WAY_W'(w);
        end
      end
      r_victim    <= '0;
      r_idx       <= '0;
      r_mtag      <= '0;
      r_fill_done <= 1'b0;
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
    end else begin
      r_fill_done <= (r_state == S_REFILL);
      if (w_do_miss) begin
        r_victim <= w_victim;
        r_idx    <= w_idx;
        r_mtag   <= w_tag;
        if (r_miss_cnt != {CNT_W{1'b1}}) r_miss_cnt <= r_miss_cnt + 1'b1;
      end
      if (w_do_hit) begin
        // The access that completes a refill is the tail of a miss, not a hit.
        if (!r_fill_done && (r_hit_cnt != {CNT_W{1'b1}})) r_hit_cnt <= r_hit_cnt + 1'b1;
        if (MemWrite_i) r_dirty[w_hit_way][w_idx] <= 1'b1;
        for (int w = 0; w < WAYS; w++) begin
          if (c_WAY_W'(w) == w_hit_way)
            r_age[w][w_idx] <= '0;
          else if (r_age[w][w_idx] < r_age[w_hit_way][w_idx])
            r_age[w][w_idx] <= r_age[w][w_idx] + 1'b1;
        end
      end
      if (r_state == S_REFILL) begin
        r_valid[r_victim][r_idx] <= 1'b1;
        r_dirty[r_victim][r_idx] <= 1'b0;
      end
    end
  end

  // Line and tag storage needs no reset: it is only observed behind valid.
  always_ff @(posedge Clk_i) begin
    if (w_do_hit && MemWrite_i)
      r_data[w_hit_way][w_idx][w_wsel*32 +: 32] <= Data_i;
    if ((r_state == S_ALLOCATE) && MemAck_i)
      r_line <= MemData_i;
    if (r_state == S_REFILL) begin
      r_data[r_victim][r_idx] <= r_line;
      r_tag[r_victim][r_idx]  <= r_mtag;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dcache_sa_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dcache_sa_controller                                                    |
// | Directed self-checking bench for dcache_sa_controller (2-way, 16 sets).   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_dcache_sa_controller;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         mem_read = 1'b0, mem_write = 1'b0;
  logic [31:0]  addr = '0, wdata = '0;

  logic [31:0]  data_o, mem_addr;
  logic         stall, mem_en, mem_wr;
  logic [255:0] mem_rdata, mem_wdata;
  logic         ack = 1'b0;
  logic [15:0]  hit_cnt, miss_cnt;
  int           ack_cnt = 0;

  logic [31:0]  d2_data_o, d2_mem_addr;
  logic         d2_stall, d2_mem_en, d2_mem_wr;
  logic [255:0] d2_mem_rdata, d2_mem_wdata;
  logic         d2_ack = 1'b0;
  logic [2:0]   d2_hit_cnt, d2_miss_cnt;
  int           d2_ack_cnt = 0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Memory image: word0 of line 0x40 is 0xDEADBEEF, other lines differ by address.
  function automatic logic [255:0] mem_line(input logic [31:0] a);
    logic [255:0] l;
    for (int k = 0; k < 8; k++)
      l[k*32 +: 32] = (k == 0) ? (32'hDEADBEEF ^ a ^ 32'h40) : {a[27:0], 4'(k)};
    return l;
  endfunction

  assign mem_rdata    = mem_line(mem_addr);
  assign d2_mem_rdata = mem_line(d2_mem_addr);

  // Ack arrives in the third cycle of each memory request.
  always @(negedge clk) begin
    if (mem_en && ack_cnt == 2) begin ack = 1'b1; ack_cnt = 0; end
    else begin ack = 1'b0; ack_cnt = mem_en ? ack_cnt + 1 : 0; end
    if (d2_mem_en && d2_ack_cnt == 2) begin d2_ack = 1'b1; d2_ack_cnt = 0; end
    else begin d2_ack = 1'b0; d2_ack_cnt = d2_mem_en ? d2_ack_cnt + 1 : 0; end
  end

  dcache_sa_controller #(.WAYS(2), .SETS(16), .LINE_BITS(256), .CNT_W(16)) dut (
    .Clk_i(clk), .Rst_i(rst), .MemRead_i(mem_read), .MemWrite_i(mem_write),
    .Addr_i(addr), .Data_i(wdata), .Data_o(data_o), .Stall_o(stall),
    .MemData_i(mem_rdata), .MemAck_i(ack), .MemData_o(mem_wdata),
    .MemAddr_o(mem_addr), .MemEnable_o(mem_en), .MemWrite_o(mem_wr),
    .HitCount_o(hit_cnt), .MissCount_o(miss_cnt)
  );

  dcache_sa_controller #(.WAYS(2), .SETS(16), .LINE_BITS(256), .CNT_W(3)) dut_sat (
    .Clk_i(clk), .Rst_i(rst), .MemRead_i(mem_read), .MemWrite_i(mem_write),
    .Addr_i(addr), .Data_i(wdata), .Data_o(d2_data_o), .Stall_o(d2_stall),
    .MemData_i(d2_mem_rdata), .MemAck_i(d2_ack), .MemData_o(d2_mem_wdata),
    .MemAddr_o(d2_mem_addr), .MemEnable_o(d2_mem_en), .MemWrite_o(d2_mem_wr),
    .HitCount_o(d2_hit_cnt), .MissCount_o(d2_miss_cnt)
  );

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_unstall(output int n);
    n = 0;
    while (stall === 1'b1 && n < 64) begin
      n++;
      cyc();
      #1;
    end
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    cyc(); cyc();
    #1;
    checks++; if ({stall, mem_en, mem_wr} !== 3'b000) begin errors++; $display("FAIL reset_ctrl: got %b expected 000", {stall, mem_en, mem_wr}); end
    checks++; if (mem_addr !== 32'h0 || data_o !== 32'h0) begin errors++; $display("FAIL reset_addr_data: got %h/%h expected 0/0", mem_addr, data_o); end
    checks++; if (mem_wdata !== 256'h0) begin errors++; $display("FAIL reset_memdata: got %h expected 0", mem_wdata); end
    checks++; if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0) begin errors++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", hit_cnt, miss_cnt); end
    cyc();
    rst = 1'b0;
    n = 0;
    cyc();
  endtask

  task automatic test_cold_miss();
    int n;
    mem_read = 1'b1; addr = 32'h40;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL cold_detect_stall: got %b expected 1", stall); end
    cyc(); #1;
    checks++; if ({mem_en, mem_wr} !== 2'b10 || mem_addr !== 32'h40) begin errors++; $display("FAIL cold_alloc: got en/wr %b addr %h expected 10 addr 00000040", {mem_en, mem_wr}, mem_addr); end
    wait_unstall(n);
    checks++; if (n + 1 !== 5) begin errors++; $display("FAIL cold_stall_cycles: got %0d expected 5", n + 1); end
    checks++; if (data_o !== 32'hDEADBEEF) begin errors++; $display("FAIL cold_data: got %h expected deadbeef", data_o); end
    checks++; if (miss_cnt !== 16'd1 || hit_cnt !== 16'd0) begin errors++; $display("FAIL cold_counts: got miss %0d hit %0d expected 1/0", miss_cnt, hit_cnt); end
    cyc();
    mem_read = 1'b0;
    #1;
    checks++; if (hit_cnt !== 16'd0) begin errors++; $display("FAIL cold_completion_not_hit: got %0d expected 0", hit_cnt); end
    cyc();
  endtask

  task automatic test_hit();
    mem_read = 1'b1; addr = 32'h40;
    #1;
    checks++; if (stall !== 1'b0 || data_o !== 32'hDEADBEEF) begin errors++; $display("FAIL hit_read: got stall %b data %h expected 0 deadbeef", stall, data_o); end
    cyc();
    mem_read = 1'b0;
    #1;
    checks++; if (hit_cnt !== 16'd1) begin errors++; $display("FAIL hit_count: got %0d expected 1", hit_cnt); end
    cyc();
  endtask

  task automatic test_write_hit();
    mem_write = 1'b1; addr = 32'h44; wdata = 32'h12345678;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL write_hit_stall: got %b expected 0", stall); end
    cyc();
    mem_write = 1'b0; mem_read = 1'b1; addr = 32'h44;
    #1;
    checks++; if (stall !== 1'b0 || data_o !== 32'h12345678) begin errors++; $display("FAIL write_then_read: got stall %b data %h expected 0 12345678", stall, data_o); end
    cyc();
    mem_read = 1'b0;
    #1;
    checks++; if (hit_cnt !== 16'd3) begin errors++; $display("FAIL write_hit_count: got %0d expected 3", hit_cnt); end
    cyc();
  endtask

  task automatic test_lru_evict();
    int n;
    mem_read = 1'b1; addr = 32'h240;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL fill240_stall: got %b expected 1", stall); end
    cyc(); #1;
    wait_unstall(n);
    checks++; if (n !== 4 || data_o !== 32'hDEADBCEF) begin errors++; $display("FAIL fill240: got n %0d data %h expected 4 deadbcef", n, data_o); end
    cyc();
    addr = 32'h440;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL evict_detect: got %b expected 1", stall); end
    cyc(); #1;
    checks++; if ({mem_en, mem_wr} !== 2'b11 || mem_addr !== 32'h40) begin errors++; $display("FAIL evict_wb_ctrl: got en/wr %b addr %h expected 11 addr 00000040", {mem_en, mem_wr}, mem_addr); end
    checks++; if (mem_wdata[63:0] !== 64'h12345678_DEADBEEF) begin errors++; $display("FAIL evict_wb_data: got %h expected 12345678deadbeef", mem_wdata[63:0]); end
    cyc(); cyc(); cyc(); #1;
    checks++; if ({mem_en, mem_wr} !== 2'b10 || mem_addr !== 32'h440) begin errors++; $display("FAIL evict_alloc: got en/wr %b addr %h expected 10 addr 00000440", {mem_en, mem_wr}, mem_addr); end
    wait_unstall(n);
    checks++; if (n !== 4 || data_o !== 32'hDEADBAEF) begin errors++; $display("FAIL evict_fill: got n %0d data %h expected 4 deadbaef", n, data_o); end
    checks++; if (miss_cnt !== 16'd3) begin errors++; $display("FAIL evict_misses: got %0d expected 3", miss_cnt); end
    cyc();
    addr = 32'h240;
    #1;
    checks++; if (stall !== 1'b0 || data_o !== 32'hDEADBCEF) begin errors++; $display("FAIL lru_keep240: got stall %b data %h expected 0 deadbcef", stall, data_o); end
    cyc();
    mem_read = 1'b0;
    cyc();
  endtask

  task automatic test_reset_mid_alloc();
    int n;
    mem_read = 1'b1; addr = 32'h40;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rstmid_detect: got %b expected 1", stall); end
    cyc(); #1;
    checks++; if ({mem_en, mem_wr} !== 2'b10) begin errors++; $display("FAIL rstmid_alloc: got %b expected 10", {mem_en, mem_wr}); end
    #1;
    rst = 1'b1;
    #1;
    checks++; if ({mem_en, stall} !== 2'b00 || miss_cnt !== 16'd0) begin errors++; $display("FAIL rstmid_drop: got en/stall %b miss %0d expected 00 0", {mem_en, stall}, miss_cnt); end
    cyc();
    rst = 1'b0;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rstmid_remiss: got %b expected 1", stall); end
    cyc(); #1;
    wait_unstall(n);
    checks++; if (n !== 4 || data_o !== 32'hDEADBEEF || miss_cnt !== 16'd1) begin errors++; $display("FAIL rstmid_refill: got n %0d data %h miss %0d expected 4 deadbeef 1", n, data_o, miss_cnt); end
    cyc();
    mem_read = 1'b0;
    cyc();
  endtask

  task automatic test_saturation();
    int n;
    rst = 1'b1;
    #1;
    cyc();
    rst = 1'b0; mem_read = 1'b1; addr = 32'h40;
    #1;
    cyc(); #1;
    wait_unstall(n);
    checks++; if (n !== 4 || d2_miss_cnt !== 3'd1) begin errors++; $display("FAIL sat_fill: got n %0d miss %0d expected 4 1", n, d2_miss_cnt); end
    cyc();
    for (int k = 1; k <= 10; k++) begin
      cyc(); #1;
      checks++; if (d2_hit_cnt !== 3'((k > 7) ? 7 : k) || hit_cnt !== 16'(k)) begin errors++; $display("FAIL sat_hit%0d: got %0d/%0d expected %0d/%0d", k, d2_hit_cnt, hit_cnt, (k > 7) ? 7 : k, k); end
    end
    mem_read = 1'b0;
    cyc(); #1;
    checks++; if (d2_hit_cnt !== 3'd7 || hit_cnt !== 16'd10) begin errors++; $display("FAIL sat_hold: got %0d/%0d expected 7/10", d2_hit_cnt, hit_cnt); end
    cyc();
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_write_hit();
    test_lru_evict();
    test_reset_mid_alloc();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/dcache_sa_controller.md
# dcache_sa_controller

Parametrised N-way set-associative, write-back, write-allocate data cache controller for the MEM stage of the pipelined CPU. It replaces the direct-mapped controller and keeps the same CPU-side stall handshake and 256-bit line memory interface. It adds configurable associativity, set count and LRU replacement, plus saturating hit and miss counters for performance measurement.

## Interface
- WAYS, 2: associativity; power of two, 1..8
- SETS, 16: sets per way; power of two, ≥2
- LINE_BITS, 256: line width; must equal the memory data width
- CNT_W, 16: width of the hit and miss counters
- Clk_i  in  1  clock
- Rst_i  in  1  reset, asynchronous, active-high
- MemRead_i  in  1  CPU load request
- MemWrite_i  in  1  CPU store request; has priority if both are high
- Addr_i  in  32  byte address, word-aligned
- Data_i  in  32  store data
- Data_o  out  32  load data; valid when Stall_o=0
- Stall_o  out  1  freeze the whole pipeline
- MemData_i  in  LINE_BITS  refill line
- MemAck_i  in  1  one-cycle memory completion pulse
- MemData_o  out  LINE_BITS  write-back line
- MemAddr_o  out  32  line-aligned memory address
- MemEnable_o  out  1  memory request
- MemWrite_o  out  1  1 = write-back, 0 = refill
- HitCount_o  out  CNT_W  saturating hit count
- MissCount_o  out  CNT_W  saturating miss count

## Operation
- Address split: offset = Addr_i[log2(LINE_BITS/8)-1:0]; word select = Addr_i[offset_msb:2]; index = next log2(SETS) bits; tag = the remaining upper bits.
- Per way and set the block holds valid, dirty, tag, a LINE_BITS data line, and an LRU age of log2(WAYS) bits. All storage is flops.
- FSM states:
  - IDLE: no request → nothing happens. On a hit, a read drives Data_o combinationally. A write updates the selected word on the clock edge and sets dirty. Either way the accessed way becomes MRU and HitCount_o increments. On a miss, Stall_o goes high and MissCount_o increments. Next state is WRITEBACK if the victim is valid and dirty, otherwise ALLOCATE.
  - WRITEBACK: MemEnable_o=1, MemWrite_o=1, MemAddr_o = {victim tag, index, 0}, MemData_o = victim line. On MemAck_i → ALLOCATE.
  - ALLOCATE: MemEnable_o=1, MemWrite_o=0, MemAddr_o = {req tag, index, 0}. On MemAck_i, MemData_i is captured → REFILL.
  - REFILL: the victim way is written with the captured line, valid=1, dirty=0 and the new tag → IDLE. In IDLE the request now hits and completes. This completion is not counted as a hit.
- Victim selection: the lowest-index invalid way; otherwise the way with age WAYS-1.
- LRU update: the accessed way's age becomes 0. Ways whose age is below the accessed way's old age increment by 1. Ages stay a permutation of 0..WAYS-1.
- Counters saturate at 2^CNT_W-1 and never wrap.
- The CPU holds MemRead_i, MemWrite_i, Addr_i and Data_i stable while Stall_o=1. Behaviour is undefined if it does not.
- MemAck_i in IDLE or REFILL is ignored.

## Timing
- Reset values, applied asynchronously and immediately:
  - state = IDLE
  - all valid and dirty bits = 0
  - way w age = w
  - counters = 0
  - Stall_o = 0, MemEnable_o = 0, MemWrite_o = 0
  - MemAddr_o = 0, Data_o = 0, MemData_o = 0
- Reset mid-transaction abandons the access; MemEnable_o drops in the same cycle.
- Hit: zero-cycle latency; Stall_o stays 0.
- Stall_o is combinational: high in the IDLE miss-detect cycle, and high throughout WRITEBACK, ALLOCATE and REFILL. It is low in the IDLE completion cycle.
- Clean miss stall: 1 + A + 1 cycles, where A is the number of ALLOCATE cycles, including the ack cycle.
- Dirty miss stall: 1 + W + A + 1 cycles, where W is the number of WRITEBACK cycles, including the ack cycle.
- MemEnable_o, MemWrite_o, MemAddr_o and MemData_o are decoded from registered state. They stay constant for the whole WRITEBACK or ALLOCATE state.

## Test plan
All scenarios use WAYS=2, SETS=16 (index = Addr[8:5], tag = Addr[31:9]) and memory ack latency of 3 cycles unless stated.
- Cold read miss, after reset, read 0x00000040:
  - Stall_o=1 and MemAddr_o=0x40, MemEnable_o=1, MemWrite_o=0.
  - Ack with word0 = 0xDEADBEEF.
  - Data_o = 0xDEADBEEF with Stall_o=0 after 5 stall cycles; MissCount_o=1, HitCount_o=0.
- Hit after fill: read 0x40 again → 0xDEADBEEF with no stall; HitCount_o=1.
- Write hit then read: write 0x12345678 to 0x44, next cycle read 0x44 → 0x12345678 with no stall; the way is dirty.
- LRU dirty eviction:
  - Fill 0x040 (dirty from a write) and 0x240; read 0x240 last.
  - Read 0x440 → WRITEBACK with MemAddr_o=0x040, MemWrite_o=1 and MemData_o carrying the written word, then ALLOCATE at 0x440.
  - A subsequent read of 0x240 hits.
- Reset mid-ALLOCATE: assert Rst_i → MemEnable_o=0 and Stall_o=0 in the same cycle; a later read of 0x40 misses.
- Saturation with CNT_W=3: 10 consecutive hits → HitCount_o=7 and stays 7.
